// File: rtl/wb_counter_bank.sv
// wb_counter_bank
//
// A bank of NCH independent WIDTH-bit counter/timer channels for the Caravel
// user area. Software reaches the channels through the management Wishbone
// slave port. Each channel can drive a toggle output onto a GPIO pad, and all
// channels share one combined interrupt on user_irq.
//
// Each channel has four modes: up-wrap, down-reload, one-shot and
// up-saturate. It also has a sticky match flag that software clears by
// writing 1. LA bit 127 freezes every counter at once.
//
// Ports
//   wb_clk_i            single clock for all logic
//   wb_rst_ni           asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i
//                       Wishbone classic slave inputs (adr[7:2] decoded)
//   wbs_ack_o           one-cycle transfer acknowledge
//   wbs_dat_o           registered read data, zero outside the ack cycle
//   la_data_in/la_oenb  bit 127: freeze request / its active-low enable
//   la_data_out         [WIDTH-1:0] = channel 0 count, rest 0
//   io_in               unused
//   io_out/io_oeb       channel c toggle / ~out_en at pad IO_BASE+c
//   irq                 irq[0] = OR of (match & irq_en), irq[2:1] = 0
//
// Register map: channel = adr[7:4], register = adr[3:2]
//   0 CTRL   [0] en, [2:1] mode, [3] irq_en, [4] out_en
//   1 COUNT
//   2 RELOAD
//   3 STATUS [0] match (sticky, write 1 to clear)

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module wb_counter_bank #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 32,
    parameter int IO_BASE = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic [127:0]             la_data_in,
    input  logic [127:0]             la_oenb,
    output logic [127:0]             la_data_out,
    input  logic [`MPRJ_IO_PADS-1:0] io_in,
    output logic [`MPRJ_IO_PADS-1:0] io_out,
    output logic [`MPRJ_IO_PADS-1:0] io_oeb,
    output logic [2:0]               irq
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    localparam logic [1:0] MODE_UP_WRAP     = 2'd0;
    localparam logic [1:0] MODE_DOWN_RELOAD = 2'd1;
    localparam logic [1:0] MODE_ONE_SHOT    = 2'd2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt     [NCH];
    logic [WIDTH-1:0] rld     [NCH];
    logic [WIDTH-1:0] cnt_nxt [NCH];
    logic [1:0]       mode    [NCH];
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   irq_en;
    logic [NCH-1:0]   out_en;
    logic [NCH-1:0]   status;
    logic [NCH-1:0]   toggle;
    logic [NCH-1:0]   match;
    logic [NCH-1:0]   shot_done;

    // ------------------------------------------------------------------
    // Bus interface
    //
    // Handshake: a request is cyc & stb while ack is low. The cycle after a
    // request, ack is high for exactly one cycle, and the read data is valid
    // in that same cycle. The master keeps cyc/stb/we/adr/dat/sel stable
    // through the ack cycle. A write commits on the clock edge that ends the
    // ack cycle, so an async reset during the transfer drops the write.
    // Because ack self-clears, a held strobe produces one transfer every
    // two cycles.
    // ------------------------------------------------------------------
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_val;
    logic        req;
    logic        wr_commit;
    logic [3:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic        freeze;

    logic [NCH-1:0] wr_ctrl;
    logic [NCH-1:0] wr_cnt;
    logic [NCH-1:0] wr_rld;
    logic [NCH-1:0] w1c;

    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_commit = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign ch_sel    = wbs_adr_i[7:4];
    assign reg_sel   = wbs_adr_i[3:2];
    assign freeze    = ~la_oenb[127] & la_data_in[127];

    // Merge the write data into an existing register, byte lane by lane.
    // Work at 32 bits so narrow counters still see the low byte lanes.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] old,
        input logic [31:0]      wd,
        input logic [3:0]       be
    );
        logic [31:0] m;
        m = 32'(old);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
        end
        return m[WIDTH-1:0];
    endfunction

    // Per-channel write strobes. Channel numbers at or above NCH match no
    // channel, so those writes are still acked but change nothing.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wr_ctrl[c] = 1'b0;
            wr_cnt[c]  = 1'b0;
            wr_rld[c]  = 1'b0;
            w1c[c]     = 1'b0;
            if (wr_commit && (ch_sel == 4'(c))) begin
                wr_ctrl[c] = (reg_sel == REG_CTRL) && wbs_sel_i[0];
                wr_cnt[c]  = (reg_sel == REG_COUNT);
                wr_rld[c]  = (reg_sel == REG_RELOAD);
                w1c[c]     = (reg_sel == REG_STATUS) && wbs_sel_i[0]
                             && wbs_dat_i[0];
            end
        end
    end

    // Read mux; unmapped channels read as zero.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_sel == 4'(c)) begin
                case (reg_sel)
                    REG_CTRL:   rd_val = {27'd0, out_en[c], irq_en[c],
                                          mode[c], en[c]};
                    REG_COUNT:  rd_val = 32'(cnt[c]);
                    REG_RELOAD: rd_val = 32'(rld[c]);
                    default:    rd_val = {31'd0, status[c]};
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= req;
            rdata_q <= (req && !wbs_we_i) ? rd_val : '0;
        end
    end

    // ------------------------------------------------------------------
    // Counting
    //
    // A COUNT write replaces the step completely. That includes the match,
    // and for a one-shot channel it also means en is not cleared.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cnt_nxt[c]   = cnt[c];
            match[c]     = 1'b0;
            shot_done[c] = 1'b0;
            if (en[c] && !freeze) begin
                case (mode[c])
                    MODE_UP_WRAP: begin
                        if (cnt[c] == rld[c]) begin
                            cnt_nxt[c] = ZERO;
                            match[c]   = 1'b1;
                        end else begin
                            cnt_nxt[c] = cnt[c] + ONE;
                        end
                    end
                    MODE_DOWN_RELOAD: begin
                        if (cnt[c] == ZERO) begin
                            cnt_nxt[c] = rld[c];
                            match[c]   = 1'b1;
                        end else begin
                            cnt_nxt[c] = cnt[c] - ONE;
                        end
                    end
                    MODE_ONE_SHOT: begin
                        if (cnt[c] == ZERO) begin
                            match[c]     = 1'b1;
                            shot_done[c] = 1'b1;
                        end else begin
                            cnt_nxt[c] = cnt[c] - ONE;
                        end
                    end
                    default: begin
                        // Up-saturate: match only on the step that arrives at
                        // RELOAD. A channel already sitting at RELOAD holds
                        // without matching again.
                        if (cnt[c] != rld[c]) begin
                            cnt_nxt[c] = cnt[c] + ONE;
                            match[c]   = (cnt_nxt[c] == rld[c]);
                        end
                    end
                endcase
            end
            if (wr_cnt[c]) begin
                cnt_nxt[c]   = byte_merge(cnt[c], wbs_dat_i, wbs_sel_i);
                match[c]     = 1'b0;
                shot_done[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c]  <= '0;
                rld[c]  <= '0;
                mode[c] <= 2'd0;
            end
            en     <= '0;
            irq_en <= '0;
            out_en <= '0;
            status <= '0;
            toggle <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c] <= cnt_nxt[c];
                if (wr_rld[c]) rld[c] <= byte_merge(rld[c], wbs_dat_i, wbs_sel_i);
                // A CTRL write in the same cycle overrides the one-shot
                // self-disable.
                if (wr_ctrl[c]) begin
                    en[c]     <= wbs_dat_i[0];
                    mode[c]   <= wbs_dat_i[2:1];
                    irq_en[c] <= wbs_dat_i[3];
                    out_en[c] <= wbs_dat_i[4];
                end else if (shot_done[c]) begin
                    en[c] <= 1'b0;
                end
                // A new match beats a coincident write-1-to-clear.
                status[c] <= (status[c] & ~w1c[c]) | match[c];
                toggle[c] <= toggle[c] ^ (match[c] & out_en[c]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;
    assign irq       = {2'b00, |(status & irq_en)};

    always_comb begin
        la_data_out            = '0;
        la_data_out[WIDTH-1:0] = cnt[0];
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        for (int c = 0; c < NCH; c++) begin
            io_out[IO_BASE + c] = toggle[c];
            io_oeb[IO_BASE + c] = ~out_en[c];
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{io_in, la_data_in[126:0], la_oenb[126:0],
                             wbs_adr_i[31:8], wbs_adr_i[1:0]};

endmodule

// File: doc/wb_counter_bank.md
Name: wb_counter_bank

Overview:
- Parametrised successor to the single-counter user-area example: NCH independent WIDTH-bit counter/timer channels in the Caravel user area.
- Software-visible through the management Wishbone slave port; drives per-channel compare outputs onto GPIO pads and a combined interrupt to user_irq.
- Adds four counting modes, sticky match status and LA-controlled global freeze.
- Instantiated directly in user_project_wrapper in place of the example counter.

Parameters:
- NCH, 4, number of counter channels (1..16).
- WIDTH, 32, counter/reload width in bits (8..32); registers are zero-extended on read.
- IO_BASE, 8, GPIO index driven by channel 0; channel c drives io_out[IO_BASE+c]; IO_BASE+NCH <= `MPRJ_IO_PADS required.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  address; only bits [7:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  128  logic analyzer in; bit 127 = freeze request.
- la_oenb  in  128  LA output-enable (active low); bit 127 must be 0 for freeze to act.
- la_data_out  out  128  [WIDTH-1:0] = channel 0 count; rest 0.
- io_in  in  `MPRJ_IO_PADS  unused.
- io_out  out  `MPRJ_IO_PADS  channel toggle outputs at IO_BASE+c; all other bits 0.
- io_oeb  out  `MPRJ_IO_PADS  ~out_en at IO_BASE+c; all other bits 1.
- irq  out  3  irq[0] = OR over c of (match[c] & irq_en[c]); irq[2:1] = 0.

Behaviour:
- Reset (async assert, sync to clock edge on release): all counts, reloads, CTRL, status and toggles = 0; wbs_ack_o=0; wbs_dat_o=0; irq=0; io_out=0; io_oeb all 1.
- Address map: channel c = adr[7:4], register = adr[3:2].
  - 0 CTRL: [0] en, [2:1] mode, [3] irq_en, [4] out_en.
  - 1 COUNT.
  - 2 RELOAD.
  - 3 STATUS: [0] match, sticky, write-1-to-clear.
  - Channel >= NCH: read 0, writes ignored, still acked.
- Wishbone:
  - cyc&stb&~ack → ack=1 next cycle for exactly one cycle (ack deasserts the following cycle even if stb is held). Latency 1; back-to-back transfers every 2 cycles.
  - Write commits on the ack cycle using wbs_sel_i byte masks; CTRL uses sel[0] only.
  - Read data is registered and valid while ack=1; wbs_dat_o=0 otherwise.
- Counting: occurs each cycle with en=1 and freeze=0 (freeze = ~la_oenb[127] & la_data_in[127]).
  - mode 0, up-wrap: count+1; when count==RELOAD, set match and count←0 next cycle.
  - mode 1, down-reload: count-1; when count==0, set match and count←RELOAD.
  - mode 2, one-shot: as mode 1, but at count==0 set match, keep 0, clear en.
  - mode 3, up-saturate: count+1 until count==RELOAD; then hold, set match once (on arrival only).
  - Arithmetic is modulo 2^WIDTH. Mode 0 with RELOAD=2^WIDTH-1 wraps naturally; mode 0 with count>RELOAD counts through the wrap.
- Match event: sets STATUS.match. If out_en=1, toggles io_out bit on the same edge.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a count step: write wins; no match evaluated that cycle.
  - W1C clear of STATUS in the same cycle as a new match: set wins.
  - Freeze has priority over en; frozen counters hold and generate no matches. Bus writes still apply while frozen.
- Writing en=0 holds the count; nothing is cleared.
- Reset mid-transfer: ack drops immediately; the pending write is lost.

Test Plan:
- Reset: hold wb_rst_ni=0 mid-count, then release → all reads return 0, io_oeb[IO_BASE+3:IO_BASE]=4'hF, irq=0.
- Mode 0: ch0 RELOAD=5, CTRL=0x19 (en, irq_en, out_en) → count sequence 0..5,0; STATUS=1 and irq[0]=1 on the cycle after count==5; io_out[8] toggles to 1; W1C STATUS → irq[0]=0.
- Mode 2: ch1 COUNT=3, CTRL=0x05 → match after 4 enabled cycles; CTRL reads 0x04 (en cleared); count stays 0.
- Byte-select: write 0xAABBCCDD to ch2 COUNT with sel=4'b0101 while en=0 → reads 0x00BB00DD.
- Freeze: ch0 running, set la_oenb[127]=0 and la_data_in[127]=1 for 10 cycles → la_data_out[31:0] constant during freeze; with la_oenb[127]=1 the same input has no effect.
- Collisions: match and STATUS W1C in the same cycle → STATUS stays 1; COUNT write coincident with reload → written value observed.
